fft_n64_digit_rev_reorder: RTL and testbench
============================================

FFT_N64_DIGIT_REV_REORDER -- requirements
Module: fft_n64_digit_rev_reorder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 33, giving the width of each real/imag component and matching the 64-point radix-4 FFT core output.
REQ-002 SHALL have port sys_clk_i  input  1  the single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port data_in_valid_i  input  1  input sample valid.
REQ-005 SHALL have port data_in_first_i  input  1  marks the first sample of a frame; qualified by data_in_valid_i.
REQ-006 SHALL have ports xk_real_i / xk_imag_i  input  DATA_WIDTH signed  FFT bin in radix-4 digit-reversed order.
REQ-007 SHALL have port data_in_ready_o  input-side ready  output  1.
REQ-008 SHALL have ports xk_real_o / xk_imag_o  output  DATA_WIDTH signed  bin in natural order.
REQ-009 SHALL have port xk_index_o  output  6  natural bin index of the current output word.
REQ-010 SHALL have ports data_out_valid_o, data_out_first_o, data_out_last_o  output  1 each  valid, index-0 marker, index-63 marker.
REQ-011 SHALL have port data_out_ready_i  input  1  downstream ready.
REQ-012 SHALL have port frame_err_o  output  1  one-cycle pulse on an aborted input frame.

Function
REQ-013 SHALL contain two 64-entry banks (ping-pong); each bank has a full flag.
REQ-014 An input beat SHALL be accepted when data_in_valid_i and data_in_ready_o are both high.
REQ-015 The write side SHALL idle until an accepted beat has data_in_first_i=1; accepted beats without first while idle are dropped.
REQ-016 The n-th accepted beat of a frame (n=0..63, n={d2,d1,d0} base 4) SHALL be written to address {n[1:0],n[3:2],n[5:4]}.
REQ-017 The 64th accepted beat SHALL set the bank full flag and switch the write side to the other bank.
REQ-018 data_in_ready_o SHALL be high exactly when the current write bank is not full.
REQ-019 An accepted beat with data_in_first_i=1 while the write count is 1..63 SHALL restart the count at 0 in the same bank, write to address 0, and pulse frame_err_o for one cycle.
REQ-020 The read side SHALL stream a full bank at addresses 0..63 in order; xk_index_o equals the address.
REQ-021 data_out_valid_o SHALL first rise on the 2nd rising edge after the edge that accepted the 64th beat, if the read side is idle.
REQ-022 Output data, index and markers SHALL hold stable while data_out_valid_o=1 and data_out_ready_i=0.
REQ-023 With data_out_ready_i held high, output SHALL deliver one word per cycle with no bubbles across the 64 words of a bank.
REQ-024 With both banks full, the next bank's word 0 SHALL follow word 63 of the previous bank with no bubble.
REQ-025 The handshake with address 63 SHALL clear that bank's full flag on the same edge; a write-side switch to that bank SHALL be allowed on the following cycle.
REQ-026 Simultaneous completion of a write on one bank and a read on the other SHALL both take effect.

Reset
REQ-027 While rst_n_i=0: both full flags, write/read counts and bank pointers SHALL be 0; data_in_ready_o=1 after release; all outputs other than data_in_ready_o SHALL be 0.
REQ-028 Reset mid-frame or mid-read SHALL discard all buffered data; memory contents need not be cleared.

Configuration
REQ-029 Macro FFT_REORDER_DIGIT_REV_EN: when defined, the write address SHALL be as in REQ-016; when undefined, the write address SHALL be n (pure ping-pong frame buffer, no reordering); all other behaviour is identical.

Verification
REQ-030 Reset -> outputs 0, data_in_ready_o=1; one frame of xk_real_i=n at beats n=0..63, ready high -> output word at index k carries real=digitrev(k) (k=1 -> 16, k=4 -> 4, k=63 -> 63), first at k=0, last at k=63, valid 2 cycles after beat 63.
REQ-031 Three back-to-back frames with data_out_ready_i=0 -> data_in_ready_o falls after the 128th beat; releasing ready -> 192 words in order without gaps.
REQ-032 Random data_out_ready_i (50%) -> no word lost, duplicated or changed while stalled.
REQ-033 First asserted at beat 20 -> frame_err_o pulses once; the frame restarting there outputs correctly.
REQ-034 rst_n_i low during word 30 of a read -> valid drops immediately; next frame after release outputs correctly.
REQ-035 Macro undefined, ramp input -> output real equals index k.

Source files
------------

// File: rtl/fft_n64_digit_rev_reorder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fft_n64_digit_rev_reorder                                    |
// | Description : Ping-pong reorder buffer behind a 64-point radix-4 FFT core. |
// |               Bins arrive in base-4 digit-reversed order and leave in      |
// |               natural order with a valid/ready handshake on both sides.    |
// |               Macro FFT_REORDER_DIGIT_REV_EN enables the digit-reversed    |
// |               write address; without it the block is a plain 2-frame       |
// |               ping-pong frame buffer.                                      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fft_n64_digit_rev_reorder #(
  parameter int DATA_WIDTH = 33
) (
  input  logic                         sys_clk_i,
  input  logic                         rst_n_i,
  input  logic                         data_in_valid_i,
  input  logic                         data_in_first_i,
  input  logic signed [DATA_WIDTH-1:0] xk_real_i,
  input  logic signed [DATA_WIDTH-1:0] xk_imag_i,
  output logic                         data_in_ready_o,
  output logic signed [DATA_WIDTH-1:0] xk_real_o,
  output logic signed [DATA_WIDTH-1:0] xk_imag_o,
  output logic [5:0]                   xk_index_o,
  output logic                         data_out_valid_o,
  output logic                         data_out_first_o,
  output logic                         data_out_last_o,
  input  logic                         data_out_ready_i,
  output logic                         frame_err_o
);

  localparam int         c_word_w    = 2 * DATA_WIDTH;
  localparam logic [5:0] c_last_addr = 6'd63;

  typedef enum logic [0:0] {
    RD_IDLE   = 1'b0,
    RD_STREAM = 1'b1
  } rd_state_t;

  // Storage: bank select is the MSB of the 7-bit address
  logic [c_word_w-1:0] r_mem [0:127];
  logic [1:0]          r_full;

  // Write side
  logic       r_wr_bank;
  logic       r_wr_busy;      // inside a frame, count is 1..63
  logic [5:0] r_wr_cnt;
  logic       r_frame_err;

  // Read side
  rd_state_t             r_rd_state;
  rd_state_t             w_rd_state_nxt;
  logic                  r_rd_bank;
  logic [5:0]            r_rd_cnt;
  logic                  r_out_bank;
  logic                  r_out_valid;
  logic [5:0]            r_out_idx;
  logic [DATA_WIDTH-1:0] r_out_re;
  logic [DATA_WIDTH-1:0] r_out_im;

  logic                w_in_accept;
  logic [5:0]          w_wr_n;
  logic [5:0]          w_wr_addr;
  logic                w_wr_en;
  logic                w_wr_done;
  logic                w_out_hs;
  logic                w_rd_release;
  logic                w_rd_load;
  logic [c_word_w-1:0] w_rd_word;

  assign data_in_ready_o = ~r_full[r_wr_bank];
  assign w_in_accept     = data_in_valid_i & data_in_ready_o;

  // A first-marked beat always lands at beat position 0, restarting any partial frame
  assign w_wr_n    = data_in_first_i ? 6'd0 : r_wr_cnt;
  assign w_wr_en   = w_in_accept & (data_in_first_i | r_wr_busy);
  assign w_wr_done = w_wr_en & (w_wr_n == c_last_addr);

`ifdef FFT_REORDER_DIGIT_REV_EN
  // Base-4 digit reversal: beat {d2,d1,d0} belongs to natural bin {d0,d1,d2}
  assign w_wr_addr = {w_wr_n[1:0], w_wr_n[3:2], w_wr_n[5:4]};
`else
  assign w_wr_addr = w_wr_n;
`endif

  assign w_out_hs     = r_out_valid & data_out_ready_i;
  assign w_rd_release = w_out_hs & (r_out_idx == c_last_addr);
  assign w_rd_word    = r_mem[{r_rd_bank, r_rd_cnt}];

  // Sample memory write; contents are never reset
  always_ff @(posedge sys_clk_i) begin
    if (w_wr_en) begin
      r_mem[{r_wr_bank, w_wr_addr}] <= {xk_real_i, xk_imag_i};
    end
  end

  // Write counter, bank pointer and aborted-frame pulse
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_wr_bank   <= 1'b0;
      r_wr_busy   <= 1'b0;
      r_wr_cnt    <= 6'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_in_accept & data_in_first_i & r_wr_busy;
      if (w_wr_en) begin
        if (w_wr_done) begin
          r_wr_cnt  <= 6'd0;
          r_wr_busy <= 1'b0;
          r_wr_bank <= ~r_wr_bank;
        end else begin
          r_wr_cnt  <= w_wr_n + 6'd1;
          r_wr_busy <= 1'b1;
        end
      end
    end
  end

  // Bank full flags: set by the write side, cleared by the handshake of word 63.
  // The two events always address different banks.
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_full <= 2'b00;
    end else begin
      if (w_wr_done) begin
        r_full[r_wr_bank] <= 1'b1;
      end
      if (w_rd_release) begin
        r_full[r_out_bank] <= 1'b0;
      end
    end
  end

  // Read FSM state register
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_state <= RD_IDLE;
    end else begin
      r_rd_state <= w_rd_state_nxt;
    end
  end

  // Read FSM next state; loads the output register whenever it is empty or draining
  always_comb begin
    w_rd_state_nxt = r_rd_state;
    w_rd_load      = 1'b0;
    case (r_rd_state)
      RD_IDLE: begin
        if (r_full[r_rd_bank]) begin
          w_rd_state_nxt = RD_STREAM;
        end
      end
      RD_STREAM: begin
        w_rd_load = ~r_out_valid | data_out_ready_i;
        // Continue straight into the other bank when it is already full
        if (w_rd_load && (r_rd_cnt == c_last_addr) && !r_full[~r_rd_bank]) begin
          w_rd_state_nxt = RD_IDLE;
        end
      end
      default: w_rd_state_nxt = RD_IDLE;
    endcase
  end

  // Read address counter and output register
  always_ff @(posedge sys_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_rd_bank   <= 1'b0;
      r_rd_cnt    <= 6'd0;
      r_out_bank  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_idx   <= 6'd0;
      r_out_re    <= '0;
      r_out_im    <= '0;
    end else begin
      if (w_rd_load) begin
        r_out_valid <= 1'b1;
        r_out_idx   <= r_rd_cnt;
        r_out_re    <= w_rd_word[c_word_w-1:DATA_WIDTH];
        r_out_im    <= w_rd_word[DATA_WIDTH-1:0];
        r_out_bank  <= r_rd_bank;
        r_rd_cnt    <= r_rd_cnt + 6'd1;
        if (r_rd_cnt == c_last_addr) begin
          r_rd_bank <= ~r_rd_bank;
        end
      end else if (w_out_hs) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign xk_real_o        = r_out_re;
  assign xk_imag_o        = r_out_im;
  assign xk_index_o       = r_out_idx;
  assign data_out_valid_o = r_out_valid;
  assign data_out_first_o = r_out_valid & (r_out_idx == 6'd0);
  assign data_out_last_o  = r_out_valid & (r_out_idx == c_last_addr);
  assign frame_err_o      = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_fft_n64_digit_rev_reorder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_fft_n64_digit_rev_reorder                                 |
// | Description : Self-checking bench for the 64-point reorder buffer with a   |
// |               frame-level scoreboard model and a directed vector table.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_fft_n64_digit_rev_reorder;

  localparam int DW = 33;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_first;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_im;
  logic          in_ready;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic [5:0]    out_idx;
  logic          out_valid;
  logic          out_first;
  logic          out_last;
  logic          out_ready;
  logic          frame_err;

  always #5 clk = ~clk;

  fft_n64_digit_rev_reorder #(.DATA_WIDTH(DW)) dut (
    .sys_clk_i       (clk),
    .rst_n_i         (rst_n),
    .data_in_valid_i (in_valid),
    .data_in_first_i (in_first),
    .xk_real_i       (in_re),
    .xk_imag_i       (in_im),
    .data_in_ready_o (in_ready),
    .xk_real_o       (out_re),
    .xk_imag_o       (out_im),
    .xk_index_o      (out_idx),
    .data_out_valid_o(out_valid),
    .data_out_first_o(out_first),
    .data_out_last_o (out_last),
    .data_out_ready_i(out_ready),
    .frame_err_o     (frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cycle    = 0;
  int n_err_seen = 0;
  bit rnd_ready = 1'b0;

  // ---------------- reference model: whole frames in, natural order out -----
  typedef struct { logic [DW-1:0] re; logic [DW-1:0] im; int idx; } word_t;
  typedef struct { logic [DW-1:0] re; logic [DW-1:0] im; logic [5:0] idx;
                   bit first; bit last; int cyc; } log_t;

  word_t         exp_q[$];
  log_t          log_q[$];
  logic [DW-1:0] cur_re[64];
  logic [DW-1:0] cur_im[64];
  bit            m_in_frame;
  int            m_cnt;
  int            m_pending;   // complete frames not yet fully delivered
  bit            m_exp_err;

  function automatic int ref_addr(int n);
`ifdef FFT_REORDER_DIGIT_REV_EN
    return (n % 4) * 16 + ((n / 4) % 4) * 4 + (n / 16);
`else
    return n;
`endif
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_in_frame = 1'b0;
    m_cnt      = 0;
    m_pending  = 0;
    m_exp_err  = 1'b0;
  endtask

  task automatic model_accept(input bit first, input logic [DW-1:0] re, input logic [DW-1:0] im);
    if (first) begin
      if (m_in_frame && m_cnt > 0) m_exp_err = 1'b1;
      m_cnt      = 0;
      m_in_frame = 1'b1;
    end
    if (m_in_frame) begin
      cur_re[m_cnt] = re;
      cur_im[m_cnt] = im;
      m_cnt++;
      if (m_cnt == 64) begin
        word_t frame[64];
        for (int n = 0; n < 64; n++) frame[ref_addr(n)] = '{cur_re[n], cur_im[n], ref_addr(n)};
        for (int k = 0; k < 64; k++) exp_q.push_back(frame[k]);
        m_pending++;
        m_in_frame = 1'b0;
        m_cnt      = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  function automatic logic [DW-1:0] rnd_word();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  // One clock cycle: snapshot pre-edge outputs, advance, update model, check
  task automatic step(output bit acc);
    bit            hs, s_valid, s_first, s_last, s_rdy;
    logic [5:0]    s_idx;
    logic [DW-1:0] s_re, s_im;
    word_t         e;
    if (rnd_ready) out_ready = 1'($urandom_range(1, 0));
    s_valid = out_valid; s_first = out_first; s_last = out_last;
    s_idx = out_idx; s_re = out_re; s_im = out_im; s_rdy = out_ready;
    acc = in_valid && (m_pending < 2);
    hs  = s_valid && s_rdy;
    @(posedge clk);
    @(negedge clk);
    cycle++;
    m_exp_err = 1'b0;
    if (acc) model_accept(in_first, in_re, in_im);
    if (hs) begin
      log_q.push_back('{s_re, s_im, s_idx, s_first, s_last, cycle});
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("out_word", {s_idx, s_re, s_im}, {6'(e.idx), e.re, e.im});
        chk("out_markers", {s_first, s_last}, {e.idx == 0, e.idx == 63});
        if (e.idx == 63) m_pending--;
      end
    end
    if (frame_err) n_err_seen++;
    chk("in_ready", in_ready, m_pending < 2);
    chk("frame_err", frame_err, m_exp_err);
    if (s_valid && !s_rdy)
      chk("stall_hold", {out_valid, out_idx, out_re, out_im}, {1'b1, s_idx, s_re, s_im});
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic send_beat(input bit first, input logic [DW-1:0] re, input logic [DW-1:0] im);
    bit acc;
    int waited;
    waited = 0;
    in_valid = 1'b1; in_first = first; in_re = re; in_im = im;
    do begin
      step(acc);
      waited++;
    end while (!acc && waited < 400);
    chk("send_timeout", acc, 1'b1);
    in_valid = 1'b0; in_first = 1'b0;
  endtask

  task automatic drain(input int bound);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || out_valid) && w < bound) begin
      idle(1);
      w++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    idle(4);
  endtask

  task automatic apply_reset();
    in_valid = 1'b0; in_first = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_outputs", {out_first, out_last, frame_err, out_idx, out_re, out_im}, '0);
    chk("rst_ready", in_ready, 1'b1);
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed vector table for the ramp frame ---------------
  typedef struct { int k; logic [DW-1:0] re; bit first; bit last; } vec_t;
  vec_t tbl[8];

  initial begin
    int c63, cv, base;
    tbl[0] = '{0, 0, 1'b1, 1'b0};
`ifdef FFT_REORDER_DIGIT_REV_EN
    tbl[1] = '{1, 16, 1'b0, 1'b0};
    tbl[2] = '{4, 4, 1'b0, 1'b0};
    tbl[3] = '{6, 36, 1'b0, 1'b0};
    tbl[4] = '{16, 1, 1'b0, 1'b0};
    tbl[5] = '{27, 57, 1'b0, 1'b0};
    tbl[6] = '{62, 47, 1'b0, 1'b0};
`else
    tbl[1] = '{1, 1, 1'b0, 1'b0};
    tbl[2] = '{4, 4, 1'b0, 1'b0};
    tbl[3] = '{6, 6, 1'b0, 1'b0};
    tbl[4] = '{16, 16, 1'b0, 1'b0};
    tbl[5] = '{27, 27, 1'b0, 1'b0};
    tbl[6] = '{62, 62, 1'b0, 1'b0};
`endif
    tbl[7] = '{63, 63, 1'b0, 1'b1};

    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_re = '0; in_im = '0; out_ready = 1'b0;
    model_reset();
    @(negedge clk);

    // Ramp frame: latency, ordering and markers
    apply_reset();
    out_ready = 1'b1;
    log_q.delete();
    for (int n = 0; n < 64; n++) send_beat(n == 0, DW'(n), DW'(-n));
    c63 = cycle;
    cv  = -1;
    for (int i = 0; i < 10 && cv < 0; i++) begin
      idle(1);
      if (out_valid) cv = cycle;
    end
    chk("valid_latency", cv - c63, 2);
    for (int i = 0; i < 100 && log_q.size() < 64; i++) idle(1);
    chk("ramp_count", log_q.size(), 64);
    if (log_q.size() >= 64) begin
      for (int i = 0; i < 8; i++) begin
        chk($sformatf("ramp_k%0d", tbl[i].k),
            {log_q[tbl[i].k].idx, log_q[tbl[i].k].re, log_q[tbl[i].k].first, log_q[tbl[i].k].last},
            {6'(tbl[i].k), tbl[i].re, tbl[i].first, tbl[i].last});
      end
      chk("ramp_no_bubble", log_q[63].cyc - log_q[0].cyc, 63);
    end
    drain(50);

    // Three back-to-back frames against a stalled output
    apply_reset();
    out_ready = 1'b0;
    log_q.delete();
    for (int n = 0; n < 128; n++) send_beat(n % 64 == 0, rnd_word(), rnd_word());
    chk("ready_low_after_128", in_ready, 1'b0);
    idle(5);
    chk("no_words_while_stalled", log_q.size(), 0);
    out_ready = 1'b1;
    for (int n = 0; n < 64; n++) send_beat(n == 0, rnd_word(), rnd_word());
    drain(300);
    chk("b2b_count", log_q.size(), 192);
    if (log_q.size() >= 128) chk("b2b_no_gap", log_q[127].cyc - log_q[0].cyc, 127);

    // Dropped beats while idle, then a frame aborted by a new first at beat 20
    apply_reset();
    out_ready = 1'b1;
    log_q.delete();
    for (int n = 0; n < 5; n++) send_beat(1'b0, rnd_word(), rnd_word());
    idle(3);
    chk("dropped_no_output", log_q.size() + exp_q.size(), 0);
    base = n_err_seen;
    for (int n = 0; n < 20; n++) send_beat(n == 0, rnd_word(), rnd_word());
    for (int n = 0; n < 64; n++) send_beat(n == 0, rnd_word(), rnd_word());
    drain(200);
    chk("err_pulses", n_err_seen - base, 1);
    chk("restart_count", log_q.size(), 64);

    // Random data, random input gaps, random downstream stalls
    apply_reset();
    log_q.delete();
    rnd_ready = 1'b1;
    for (int f = 0; f < 5; f++) begin
      for (int n = 0; n < 64; n++) begin
        idle($urandom_range(2, 0));
        send_beat(n == 0, rnd_word(), rnd_word());
      end
    end
    drain(3000);
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    chk("random_count", log_q.size(), 320);

    // Reset while word 30 of a bank is on the output
    apply_reset();
    out_ready = 1'b1;
    log_q.delete();
    for (int n = 0; n < 64; n++) send_beat(n == 0, rnd_word(), rnd_word());
    for (int i = 0; i < 200 && log_q.size() < 30; i++) idle(1);
    chk("midread_reached", log_q.size(), 30);
    apply_reset();
    log_q.delete();
    for (int n = 0; n < 64; n++) send_beat(n == 0, rnd_word(), rnd_word());
    drain(200);
    chk("post_reset_count", log_q.size(), 64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
